// File: rtl/timer_if.sv
// Bus bundle between the timer core and its register/interrupt block.
// The register block drives the controls and the core returns status.
interface timer_if #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
);
  logic               clk_pulse;
  logic               use_ext;
  logic               enable;
  logic               trigger;
  logic               periodic;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   reload;
  logic               irq_clr;
  logic [WIDTH-1:0]   count;
  logic               running;
  logic               expire_pulse;
  logic               irq;

  modport master (
    output clk_pulse, use_ext, enable, trigger, periodic, prescale, reload, irq_clr,
    input  count, running, expire_pulse, irq
  );

  modport slave (
    input  clk_pulse, use_ext, enable, trigger, periodic, prescale, reload, irq_clr,
    output count, running, expire_pulse, irq
  );
endinterface

// File: rtl/timer_core.sv
// Prescaled down-counter timer with one-shot/periodic modes, expiry pulse
// and sticky interrupt. All outputs are registered.
module timer_core #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  timer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   count;
  logic [PRESC_W-1:0] presc_cnt;
  logic               running;
  logic               expire_pulse;
  logic               irq;

  logic src;
  logic presc_hit;
  logic tick;
  logic expiring;

  always_comb begin
    src       = bus.use_ext ? bus.clk_pulse : 1'b1;
    presc_hit = (presc_cnt == bus.prescale);
    tick      = (state == RUN) && src && presc_hit;
    // A trigger or a disable in the same cycle suppresses the expiry entirely.
    expiring  = bus.enable && !bus.trigger && tick && (count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      presc_cnt    <= '0;
      running      <= 1'b0;
      expire_pulse <= 1'b0;
      irq          <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      if (!bus.enable) begin
        state     <= IDLE;
        presc_cnt <= '0;
        running   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARMED;
          end
          ARMED, DONE: begin
            if (bus.trigger) begin
              state     <= RUN;
              count     <= bus.reload;
              presc_cnt <= '0;
              running   <= 1'b1;
            end
          end
          RUN: begin
            if (bus.trigger) begin
              count     <= bus.reload;
              presc_cnt <= '0;
            end else if (src) begin
              if (presc_hit) begin
                presc_cnt <= '0;
                if (count != '0) begin
                  count <= count - WIDTH'(1);
                end else begin
                  expire_pulse <= 1'b1;
                  if (bus.periodic) begin
                    count <= bus.reload;
                  end else begin
                    state   <= DONE;
                    running <= 1'b0;
                  end
                end
              end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
      // Set has priority over a simultaneous clear.
      if (expiring) irq <= 1'b1;
      else if (bus.irq_clr) irq <= 1'b0;
    end
  end

  assign bus.count        = count;
  assign bus.running      = running;
  assign bus.expire_pulse = expire_pulse;
  assign bus.irq          = irq;
endmodule
